// File: rtl/ol_dpwm.sv
// ol_dpwm: free-running counter PWM with period-boundary on-time shadowing and sync strobe.
// Define DEADTIME_EN to add a complementary low-side gate with DT-cycle dead time.
module ol_dpwm #(
   parameter int CNT_W  = 11,
   parameter int PERIOD = 1000,
   parameter int DT     = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_ton,
   output logic             o_pwm_hs,
   output logic             o_pwm_ls,
   output logic             o_sync,
   output logic [CNT_W-1:0] o_ton_act,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);

   // The named block shows up in elaboration reports when the parameter set is unusable
   if (PERIOD < 2 || PERIOD > (2 ** CNT_W) - 1 || DT < 0) begin : g_param_range_violation
   end

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] ton_act;
   logic             hs_raw;
   logic             gate_run;
   logic             hs_raw_d;
   logic             hs_raw_q;

   function automatic logic [CNT_W-1:0] clamp_ton(input logic [CNT_W-1:0] ton);
      return (ton > PERIOD_C) ? PERIOD_C : ton;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ton_act <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (i_en) begin
                  state   <= RUN;
                  ton_act <= clamp_ton(i_ton);
               end
            end
            RUN: begin
               if (!i_en) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == LAST_C) begin
                  cnt     <= '0;
                  ton_act <= clamp_ton(i_ton);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign hs_raw    = (state == RUN) && (cnt < ton_act);
   assign o_sync    = (state == RUN) && (cnt == '0);
   assign o_cnt     = cnt;
   assign o_ton_act = ton_act;

   // Gates are cleared on the same edge that samples i_en low, not one edge later
   assign gate_run = (state == RUN) && i_en;
   assign hs_raw_d = gate_run && hs_raw;

`ifdef DEADTIME_EN
   localparam logic [CNT_W-1:0] DT_C = CNT_W'(DT);

   logic             run_q;
   logic [CNT_W-1:0] dt_cnt;
   logic [CNT_W-1:0] dt_nxt;
   logic             hs_chg;

   // Entering RUN is treated as a transition out of "both off"
   assign hs_chg = (hs_raw_d != hs_raw_q) || (gate_run && !run_q);

   always_comb begin
      dt_nxt = dt_cnt;
      if (!gate_run)
         dt_nxt = '0;
      else if (hs_chg)
         dt_nxt = DT_C;
      else if (dt_cnt != '0)
         dt_nxt = dt_cnt - 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_raw_q <= 1'b0;
         run_q    <= 1'b0;
         dt_cnt   <= '0;
         o_pwm_hs <= 1'b0;
         o_pwm_ls <= 1'b0;
      end else begin
         hs_raw_q <= hs_raw_d;
         run_q    <= gate_run;
         dt_cnt   <= dt_nxt;
         o_pwm_hs <= gate_run && (dt_nxt == '0) && hs_raw_d;
         o_pwm_ls <= gate_run && (dt_nxt == '0) && !hs_raw_d;
      end
   end
`else
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         hs_raw_q <= 1'b0;
      else
         hs_raw_q <= hs_raw_d;
   end

   // Asynchronous buck: the freewheel path is a diode, so the low-side gate stays off
   assign o_pwm_hs = hs_raw_q;
   assign o_pwm_ls = 1'b0;
`endif

endmodule

// File: tb/tb_ol_dpwm.sv
// Self-checking bench for ol_dpwm: directed scenarios plus randomized traffic against a
// period/age based reference model; follows DEADTIME_EN when it is defined.
module tb_ol_dpwm;

   localparam int CNT_W  = 11;
   localparam int PERIOD = 1000;
   localparam int DT     = 8;

   logic             i_clk   = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_en    = 1'b0;
   logic [CNT_W-1:0] i_ton   = '0;
   logic             o_pwm_hs;
   logic             o_pwm_ls;
   logic             o_sync;
   logic [CNT_W-1:0] o_ton_act;
   logic [CNT_W-1:0] o_cnt;

   int tests = 0;
   int fails = 0;

   always #5 i_clk = ~i_clk;

   ol_dpwm #(.CNT_W(CNT_W), .PERIOD(PERIOD), .DT(DT)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (i_en),
      .i_ton    (i_ton),
      .o_pwm_hs (o_pwm_hs),
      .o_pwm_ls (o_pwm_ls),
      .o_sync   (o_sync),
      .o_ton_act(o_ton_act),
      .o_cnt    (o_cnt)
   );

   // Reference model: m_age counts cycles since the modulator started (-1 when idle);
   // the counter value is its remainder modulo PERIOD and on-time latches when that is 0.
   int m_age  = -1;
   int m_ton  = 0;
   bit m_hsq  = 1'b0;
   bit hist_hs[$];
   bit hist_run[$];

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_age = -1;
      m_ton = 0;
      m_hsq = 1'b0;
      hist_hs.delete();
      hist_run.delete();
   endtask

   task automatic model_edge(input bit en, input int ton);
      bit raw;
      bit was_run;
      was_run = (m_age >= 0);
      raw     = was_run && ((m_age % PERIOD) < m_ton);
      m_hsq   = en && raw;
      hist_hs.push_front(m_hsq);
      hist_run.push_front(en && was_run);
      if (hist_hs.size() > DT + 1) begin
         void'(hist_hs.pop_back());
         void'(hist_run.pop_back());
      end
      if (!en) begin
         m_age = -1;
      end else begin
         m_age = m_age + 1;
         if (m_age % PERIOD == 0) m_ton = min_int(ton, PERIOD);
      end
   endtask

   // A gate is on only when the last DT+1 registered samples were all running at that level
   function automatic bit window_all(input bit level);
      if (hist_hs.size() < DT + 1) return 1'b0;
      foreach (hist_hs[i])
         if (!hist_run[i] || hist_hs[i] != level) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit exp_hs_now();
`ifdef DEADTIME_EN
      return window_all(1'b1);
`else
      return m_hsq;
`endif
   endfunction

   function automatic bit exp_ls_now();
`ifdef DEADTIME_EN
      return window_all(1'b0);
`else
      return 1'b0;
`endif
   endfunction

   // Expected gate-high cycles per period at a steady on-time
   function automatic int exp_hs_width(input int ton_eff);
`ifdef DEADTIME_EN
      if (ton_eff >= PERIOD) return PERIOD;
      return (ton_eff > DT) ? ton_eff - DT : 0;
`else
      return ton_eff;
`endif
   endfunction

   function automatic int exp_ls_width(input int ton_eff);
`ifdef DEADTIME_EN
      return (PERIOD - ton_eff > DT) ? PERIOD - ton_eff - DT : 0;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("cnt",     32'(o_cnt),     32'((m_age < 0) ? 0 : m_age % PERIOD));
      chk("sync",    32'(o_sync),    32'((m_age >= 0) && (m_age % PERIOD == 0)));
      chk("ton_act", 32'(o_ton_act), 32'(m_ton));
      chk("pwm_hs",  32'(o_pwm_hs),  32'(exp_hs_now()));
      chk("pwm_ls",  32'(o_pwm_ls),  32'(exp_ls_now()));
   endtask

   task automatic cycle();
      @(posedge i_clk);
      if (!i_rst_n) model_reset();
      else          model_edge(i_en, int'(i_ton));
      #1;
      check_all();
   endtask

   task automatic wait_sync(input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (o_sync !== 1'b1 && n < 2 * PERIOD + 10);
      chk(tag, 32'(o_sync), 32'd1);
   endtask

   task automatic wait_cnt(input string tag, input int target);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (o_cnt !== CNT_W'(target) && n < 2 * PERIOD + 10);
      chk(tag, 32'(o_cnt), 32'(target));
   endtask

   task automatic measure(input int n, output int hs_n, output int ls_n, output int sync_n);
      hs_n = 0; ls_n = 0; sync_n = 0;
      repeat (n) begin
         cycle();
         hs_n   += int'(o_pwm_hs);
         ls_n   += int'(o_pwm_ls);
         sync_n += int'(o_sync);
      end
   endtask

   task automatic async_reset(input int hold_cycles);
      #3;
      i_rst_n = 1'b0;
      #1;
      chk("rst_hs",      32'(o_pwm_hs),  32'd0);
      chk("rst_ls",      32'(o_pwm_ls),  32'd0);
      chk("rst_sync",    32'(o_sync),    32'd0);
      chk("rst_cnt",     32'(o_cnt),     32'd0);
      chk("rst_ton_act", 32'(o_ton_act), 32'd0);
      model_reset();
      repeat (hold_cycles) cycle();
      i_rst_n = 1'b1;
   endtask

   initial begin
      int hs_n, ls_n, sync_n;

      // Power-on reset, then release with the modulator disabled
      repeat (3) cycle();
      i_rst_n = 1'b1;
      repeat (5) cycle();

      // Steady duty and first-pulse latency
      i_ton = 11'd250;
      i_en  = 1'b1;
      cycle();
      chk("entry_sync", 32'(o_sync), 32'd1);
      chk("entry_hs",   32'(o_pwm_hs), 32'd0);
      wait_sync("steady_sync");
      measure(PERIOD, hs_n, ls_n, sync_n);
      chk("steady_hs_width", 32'(hs_n),   32'(exp_hs_width(250)));
      chk("steady_ls_width", 32'(ls_n),   32'(exp_ls_width(250)));
      chk("steady_sync_cnt", 32'(sync_n), 32'd1);

      // Shadow update mid-period
      wait_cnt("shadow_at100", 100);
      i_ton = 11'd500;
      cycle();
      chk("shadow_hold", 32'(o_ton_act), 32'd250);
      wait_sync("shadow_wrap");
      chk("shadow_new", 32'(o_ton_act), 32'd500);
      measure(PERIOD, hs_n, ls_n, sync_n);
      chk("shadow_hs_width", 32'(hs_n), 32'(exp_hs_width(500)));
      chk("shadow_ls_width", 32'(ls_n), 32'(exp_ls_width(500)));

      // Limits: 0 %, 100 %, over-range, and a pulse shorter than the dead time
      i_ton = 11'd0;
      wait_sync("zero_sync");
      measure(PERIOD, hs_n, ls_n, sync_n);
      chk("zero_hs_width", 32'(hs_n), 32'd0);
      i_ton = 11'd1000;
      wait_sync("full_sync");
      wait_sync("full_sync2");
      measure(PERIOD, hs_n, ls_n, sync_n);
      chk("full_hs_width", 32'(hs_n), 32'(PERIOD));
      i_ton = 11'd1500;
      wait_sync("over_sync");
      chk("over_clamp", 32'(o_ton_act), 32'(PERIOD));
      measure(PERIOD, hs_n, ls_n, sync_n);
      chk("over_hs_width", 32'(hs_n), 32'(PERIOD));
      i_ton = 11'd5;
      wait_sync("short_sync");
      wait_sync("short_sync2");
      measure(PERIOD, hs_n, ls_n, sync_n);
      chk("short_hs_width", 32'(hs_n), 32'(exp_hs_width(5)));

      // Shutdown mid-pulse and restart
      i_ton = 11'd500;
      wait_sync("shut_sync");
      wait_cnt("shut_at300", 300);
      i_en = 1'b0;
      cycle();
      chk("shut_hs",   32'(o_pwm_hs), 32'd0);
      chk("shut_cnt",  32'(o_cnt),    32'd0);
      chk("shut_sync", 32'(o_sync),   32'd0);
      repeat (10) cycle();
      i_en = 1'b1;
      cycle();
      chk("restart_cnt",  32'(o_cnt),  32'd0);
      chk("restart_sync", 32'(o_sync), 32'd1);

      // Asynchronous reset in the middle of a high pulse
      wait_cnt("rst_at200", 200);
      chk("rst_pre_hs", 32'(o_pwm_hs), 32'(exp_hs_width(500) > 0));
      i_en = 1'b0;
      async_reset(2);
      repeat (20) cycle();

      // Randomized on-time, enable and reset activity
      i_en = 1'b1;
      repeat (8000) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 5))
               0:       i_ton = 11'd0;
               1:       i_ton = 11'd1000;
               2:       i_ton = CNT_W'($urandom_range(1001, 2047));
               3:       i_ton = CNT_W'($urandom_range(0, 2 * DT + 2));
               default: i_ton = CNT_W'($urandom_range(0, 999));
            endcase
         end
         if ($urandom_range(0, 1199) == 0) i_en = ~i_en;
         if (!i_en && $urandom_range(0, 49) == 0) i_en = 1'b1;
         if ($urandom_range(0, 3999) == 0) async_reset(1);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
